// File: rtl/alu_md_unit.sv
// Execute-stage ALU for the RV32I pipeline with an optional iterative
// M-extension multiply/divide engine (one shift-add / restoring step per cycle).
module alu_md_unit #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [1:0]      ALUOp,
  input  logic            opb5,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            result_valid_o,
  output logic            stall_o,
  output logic            illegal_o
);

  localparam int unsigned SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_SRA, A_OR, A_AND
  } alu_op_t;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  alu_op_t         op;
  logic            illegal_dec, mtype, mop, vld;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;

  // ---------------- decode ----------------
  always_comb begin
    op          = A_ADD;
    illegal_dec = 1'b0;
    mtype       = 1'b0;
    case (ALUOp)
      2'b00: op = A_ADD;
      2'b01: begin
        case (funct3)
          3'b000, 3'b001: op = A_SUB;
          3'b100, 3'b101: op = A_SLT;
          3'b110, 3'b111: op = A_SLTU;
          default:        illegal_dec = 1'b1;
        endcase
      end
      2'b10: begin
        if (opb5 && funct7 == 7'b0000001) begin
          mtype = 1'b1;
        end else begin
          case (funct3)
            3'b000:  op = (opb5 && funct7[5]) ? A_SUB : A_ADD;
            3'b001:  op = A_SLL;
            3'b010:  op = A_SLT;
            3'b011:  op = A_SLTU;
            3'b100:  op = A_XOR;
            3'b101:  op = funct7[5] ? A_SRA : A_SRL;
            3'b110:  op = A_OR;
            default: op = A_AND;
          endcase
        end
      end
      default: illegal_dec = 1'b1;
    endcase
  end

  // Reset also masks the inputs so all outputs show reset values while held.
  assign vld       = valid_i & reset_n;
  assign mop       = mtype & ENABLE_M;
  assign illegal_o = vld & (illegal_dec | (mtype & ~ENABLE_M));
  assign shamt     = srcb[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      A_ADD:  alu_res = srca + srcb;
      A_SUB:  alu_res = srca - srcb;
      A_SLL:  alu_res = srca << shamt;
      A_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
      A_SLTU: alu_res = {{(XLEN-1){1'b0}}, srca < srcb};
      A_XOR:  alu_res = srca ^ srcb;
      A_SRL:  alu_res = srca >> shamt;
      A_SRA:  alu_res = $signed(srca) >>> shamt;
      A_OR:   alu_res = srca | srcb;
      A_AND:  alu_res = srca & srcb;
      default: alu_res = '0;
    endcase
  end

  // ---------------- M-extension operand preparation ----------------
  logic            sgn_a, sgn_b, neg_a, neg_b, div0, ovf;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;

  always_comb begin
    sgn_a    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    sgn_b    = funct3[2] ? ~funct3[0] : ~funct3[1];
    neg_a    = sgn_a & srca[XLEN-1];
    neg_b    = sgn_b & srcb[XLEN-1];
    mag_a    = neg_a ? -srca : srca;
    mag_b    = neg_b ? -srcb : srcb;
    div0     = funct3[2] & (srcb == '0);
    ovf      = funct3[2] & ~funct3[0] & (srca == MIN_NEG) & (srcb == '1);
    if (funct3[1]) spec_res = div0 ? srca : '0;
    else           spec_res = div0 ? '1 : srca;
  end

  // ---------------- datapath state ----------------
  state_t            state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d, res_q, res_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d, nrem_q, nrem_d;

  // acc holds {partial product hi, multiplier} or {remainder, quotient}
  logic [XLEN:0]     mul_sum, div_rsh, div_diff;
  logic [2*XLEN-1:0] step, fin_p;
  logic [XLEN-1:0]   q_fin, r_fin, fin_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_rsh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_rsh - {1'b0, opnd_q};
    if (!f3_q[2])             step = {mul_sum, acc_q[XLEN-1:1]};
    else if (!div_diff[XLEN]) step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                      step = {div_rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    fin_p = neg_q ? -step : step;
    q_fin = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    r_fin = nrem_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    if (f3_q[2])                fin_res = f3_q[1] ? r_fin : q_fin;
    else if (f3_q[1:0] == 2'b00) fin_res = fin_p[XLEN-1:0];
    else                        fin_res = fin_p[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      nrem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      nrem_q  <= nrem_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    opnd_d         = opnd_q;
    res_d          = res_q;
    f3_d           = f3_q;
    neg_d          = neg_q;
    nrem_d         = nrem_q;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    result_o       = '0;
    case (state_q)
      S_IDLE: begin
        if (vld && mop && !flush_i) begin
          stall_o = 1'b1;
          f3_d    = funct3;
          neg_d   = neg_a ^ neg_b;
          nrem_d  = neg_a;
          if (div0 || ovf) begin
            res_d   = spec_res;
            state_d = S_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
            opnd_d  = funct3[2] ? mag_b : mag_a;
            cnt_d   = SW'(XLEN - 1);
            state_d = S_BUSY;
          end
        end else if (vld && !illegal_o && !mtype) begin
          result_o       = alu_res;
          result_valid_o = ~flush_i;
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          stall_o = 1'b1;
          acc_d   = step;
          if (cnt_q == '0) begin
            res_d   = fin_res;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          result_o       = res_q;
          result_valid_o = vld;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed bench for alu_md_unit: single-cycle vector table plus multi-cycle
// MUL/DIV, special-case, flush and reset sequences.
module tb_alu_md_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            valid_i, flush_i, opb5;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] srca, srcb;
  logic [XLEN-1:0] result_o, result0;
  logic            zero_o, result_valid_o, stall_o, illegal_o;
  logic            zero0, rv0, stall0, ill0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_md_unit #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .flush_i(flush_i),
    .ALUOp(ALUOp), .opb5(opb5), .funct3(funct3), .funct7(funct7),
    .srca(srca), .srcb(srcb), .result_o(result_o), .zero_o(zero_o),
    .result_valid_o(result_valid_o), .stall_o(stall_o), .illegal_o(illegal_o)
  );

  alu_md_unit #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .flush_i(flush_i),
    .ALUOp(ALUOp), .opb5(opb5), .funct3(funct3), .funct7(funct7),
    .srca(srca), .srcb(srcb), .result_o(result0), .zero_o(zero0),
    .result_valid_o(rv0), .stall_o(stall0), .illegal_o(ill0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  aluop;
    logic        opb5;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  vec_t vt[16];

  // Present an M-type op and follow it to completion.
  task automatic run_mop(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k;
    int stalls;
    bit got;
    @(posedge clk); #1;
    valid_i = 1'b1; flush_i = 1'b0; ALUOp = 2'b10; opb5 = 1'b1;
    funct3 = f3; funct7 = 7'b0000001; srca = a; srcb = b;
    #1;
    chk({nm, ".t0_rv"}, 32'(result_valid_o), 32'd0);
    chk({nm, ".t0_ill"}, 32'(illegal_o), 32'd0);
    stalls = int'(stall_o);
    got = 1'b0;
    k = 0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(posedge clk); #2;
      if (result_valid_o) begin
        got = 1'b1;
        k = c;
      end else if (stall_o) begin
        stalls++;
      end
    end
    chk({nm, ".latency"}, 32'(k), 32'(lat));
    chk({nm, ".stalls"}, 32'(stalls), 32'(lat));
    chk({nm, ".result"}, result_o, exp);
    @(posedge clk); #1;
    valid_i = 1'b0;
    #1;
    chk({nm, ".after_stall"}, 32'(stall_o), 32'd0);
    @(posedge clk); #2;
    chk({nm, ".idle_stall"}, 32'(stall_o | result_valid_o), 32'd0);
  endtask

  initial begin
    int rv_seen;

    vt[0]  = '{2'b10, 1'b1, 3'b000, 7'b0100000, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0};
    vt[1]  = '{2'b01, 1'b0, 3'b110, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0};
    vt[2]  = '{2'b01, 1'b0, 3'b100, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0};
    vt[3]  = '{2'b00, 1'b0, 3'b010, 7'b0000000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0};
    vt[4]  = '{2'b10, 1'b0, 3'b000, 7'b0100000, 32'd10,       32'd3,        32'd13,       1'b0};
    vt[5]  = '{2'b10, 1'b1, 3'b001, 7'b0000000, 32'd1,        32'h23,       32'd8,        1'b0};
    vt[6]  = '{2'b10, 1'b1, 3'b010, 7'b0000000, 32'hFFFFFFFE, 32'd1,        32'd1,        1'b0};
    vt[7]  = '{2'b10, 1'b1, 3'b011, 7'b0000000, 32'hFFFFFFFE, 32'd1,        32'd0,        1'b0};
    vt[8]  = '{2'b10, 1'b1, 3'b100, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    vt[9]  = '{2'b10, 1'b1, 3'b101, 7'b0000000, 32'h80000000, 32'd4,        32'h08000000, 1'b0};
    vt[10] = '{2'b10, 1'b1, 3'b101, 7'b0100000, 32'h80000000, 32'd4,        32'hF8000000, 1'b0};
    vt[11] = '{2'b10, 1'b1, 3'b110, 7'b0000000, 32'h00FF0000, 32'h0000FF00, 32'h00FFFF00, 1'b0};
    vt[12] = '{2'b10, 1'b1, 3'b111, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vt[13] = '{2'b01, 1'b0, 3'b000, 7'b0000000, 32'h1234,     32'h1234,     32'd0,        1'b0};
    vt[14] = '{2'b11, 1'b0, 3'b000, 7'b0000000, 32'd5,        32'd7,        32'd0,        1'b1};
    vt[15] = '{2'b01, 1'b0, 3'b010, 7'b0000000, 32'd5,        32'd7,        32'd0,        1'b1};

    reset_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ALUOp = 2'b00; opb5 = 1'b0;
    funct3 = '0; funct7 = '0; srca = '0; srcb = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset.result", result_o, 32'd0);
    chk("reset.zero", 32'(zero_o), 32'd1);
    chk("reset.rv", 32'(result_valid_o), 32'd0);
    chk("reset.stall", 32'(stall_o), 32'd0);
    chk("reset.ill", 32'(illegal_o), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      valid_i = 1'b1; ALUOp = vt[i].aluop; opb5 = vt[i].opb5; funct3 = vt[i].f3;
      funct7 = vt[i].f7; srca = vt[i].a; srcb = vt[i].b;
      #1;
      chk($sformatf("vec%0d.result", i), result_o, vt[i].res);
      chk($sformatf("vec%0d.zero", i), 32'(zero_o), 32'(vt[i].res == 32'd0));
      chk($sformatf("vec%0d.rv", i), 32'(result_valid_o), 32'(!vt[i].ill));
      chk($sformatf("vec%0d.stall", i), 32'(stall_o), 32'd0);
      chk($sformatf("vec%0d.ill", i), 32'(illegal_o), 32'(vt[i].ill));
    end
    @(posedge clk); #1;
    valid_i = 1'b0;

    // mul encoding on the M-less variant is illegal and never stalls
    valid_i = 1'b1; ALUOp = 2'b10; opb5 = 1'b1; funct3 = 3'b000; funct7 = 7'b0000001;
    srca = 32'd3; srcb = 32'd4;
    #1;
    chk("nom.ill", 32'(ill0), 32'd1);
    chk("nom.result", result0, 32'd0);
    chk("nom.stall", 32'(stall0), 32'd0);
    chk("nom.rv", 32'(rv0), 32'd0);
    // flush in IDLE blocks acceptance
    flush_i = 1'b1;
    #1;
    chk("flush_idle.stall", 32'(stall_o), 32'd0);
    chk("flush_idle.rv", 32'(result_valid_o), 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("flush_idle.no_start", 32'(stall_o), 32'd0);

    run_mop("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_mop("mul",    3'b000, 32'd6,        32'hFFFFFFF9, 32'hFFFFFFD6, 33);
    run_mop("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_mop("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run_mop("div_ovf",3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_mop("rem_z",  3'b110, 32'd7,        32'd0,        32'd7,        1);
    run_mop("divu_z", 3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1);
    run_mop("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_mop("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_mop("div",    3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33);
    run_mop("rem",    3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33);

    // flush at T+10 of a divu
    @(posedge clk); #1;
    valid_i = 1'b1; ALUOp = 2'b10; opb5 = 1'b1; funct3 = 3'b101; funct7 = 7'b0000001;
    srca = 32'd100; srcb = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    #1;
    chk("flush_busy.stall", 32'(stall_o), 32'd0);
    chk("flush_busy.rv", 32'(result_valid_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (result_valid_o || stall_o) rv_seen++;
    end
    chk("flush_busy.quiet", 32'(rv_seen), 32'd0);

    // reset pulse at T+5 of a divu
    @(posedge clk); #1;
    valid_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid.pre_stall", 32'(stall_o), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid.result", result_o, 32'd0);
    chk("rst_mid.zero", 32'(zero_o), 32'd1);
    chk("rst_mid.rv", 32'(result_valid_o), 32'd0);
    chk("rst_mid.stall", 32'(stall_o), 32'd0);
    chk("rst_mid.ill", 32'(illegal_o), 32'd0);
    valid_i = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rv_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (result_valid_o || stall_o) rv_seen++;
    end
    chk("rst_mid.quiet", 32'(rv_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
